led_matrix_scanner: RTL and testbench

Row-multiplexing display driver for the 8x8 LED matrix. It consumes a 64-bit frame word from the upstream frame source, double-buffers it so frames never tear mid-scan, and drives one row at a time. Each row is lit for a programmable hold time, followed by a blanking gap that suppresses ghosting. It sits directly between the frame generator and the matrix pins, and refreshes the last accepted frame continuously.

---
 rtl/led_matrix_scanner.sv | 134 +++++++++++++
 tb/tb_led_matrix_scanner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_scanner.sv
// 8x8 LED matrix row scanner: double-buffered frame word, per-row hold time,
// blanking gap between rows, continuous refresh of the last accepted frame.
module led_matrix_scanner #(
   parameter int ROW_HOLD_CYCLES = 1000,
   parameter int BLANK_CYCLES    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] frame_in,
   input  logic        frame_valid,
   output logic [7:0]  row_sel,
   output logic [7:0]  col_data,
   output logic        frame_done,
   output logic        frame_pending
);

   localparam int MAX_N = (ROW_HOLD_CYCLES > BLANK_CYCLES) ? ROW_HOLD_CYCLES : BLANK_CYCLES;
   localparam int CW    = (MAX_N > 1) ? $clog2(MAX_N) : 1;
   localparam logic [CW-1:0] HOLD_LAST  = CW'(ROW_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, DISPLAY, BLANK} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [2:0]      row_reg, row_next;
   logic [63:0]     active_reg;
   logic [63:0]     pending_reg;
   logic            pending_full_reg;
   logic            done_stage_reg;
   logic            frame_end;
   logic [7:0]      row_sel_reg;
   logic [7:0]      col_data_reg;
   logic            frame_done_reg;
   logic [7:0]      row_bytes [8];

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_row_bytes
         assign row_bytes[gi] = active_reg[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + CW'(1);
      row_next   = row_reg;
      frame_end  = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            // A word arriving this edge is already in pending when LOAD runs.
            if (pending_full_reg || frame_valid)
               state_next = LOAD;
         end
         LOAD: begin
            cnt_next   = '0;
            row_next   = 3'd0;
            state_next = DISPLAY;
         end
         DISPLAY: begin
            if (cnt_reg == HOLD_LAST) begin
               cnt_next   = '0;
               state_next = BLANK;
            end
         end
         BLANK: begin
            if (cnt_reg == BLANK_LAST) begin
               cnt_next = '0;
               if (row_reg != 3'd7) begin
                  row_next   = row_reg + 3'd1;
                  state_next = DISPLAY;
               end else begin
                  frame_end = 1'b1;
                  if (pending_full_reg) begin
                     state_next = LOAD;
                  end else begin
                     row_next   = 3'd0;
                     state_next = DISPLAY;
                  end
               end
            end
         end
         default: begin
            cnt_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg        <= IDLE;
         cnt_reg          <= '0;
         row_reg          <= 3'd0;
         active_reg       <= '0;
         pending_reg      <= '0;
         pending_full_reg <= 1'b0;
         done_stage_reg   <= 1'b0;
         frame_done_reg   <= 1'b0;
         row_sel_reg      <= 8'd0;
         col_data_reg     <= 8'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         row_reg   <= row_next;
         if (state_reg == LOAD)
            active_reg <= pending_reg;
         if (frame_valid) begin
            pending_reg      <= frame_in;
            pending_full_reg <= 1'b1;
         end else if (state_reg == LOAD) begin
            pending_full_reg <= 1'b0;
         end
         // Pins trail the state by one cycle; the extra stage keeps frame_done
         // on the first pin cycle after row 7's blank.
         done_stage_reg <= frame_end;
         frame_done_reg <= done_stage_reg;
         if (state_reg == DISPLAY) begin
            row_sel_reg  <= 8'd1 << row_reg;
            col_data_reg <= row_bytes[row_reg];
         end else begin
            row_sel_reg  <= 8'd0;
            col_data_reg <= 8'd0;
         end
      end
   end

   assign row_sel       = row_sel_reg;
   assign col_data      = col_data_reg;
   assign frame_done    = frame_done_reg;
   assign frame_pending = pending_full_reg;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench for led_matrix_scanner: directed scenarios with random
// frame words, checked every cycle against a position-based scan model.
module tb_led_matrix_scanner;

   localparam int H  = 4;
   localparam int B  = 2;
   localparam int P  = H + B;
   localparam int FR = 8 * P;

   logic        clk;
   logic        rst;
   logic [63:0] frame_in;
   logic        frame_valid;
   logic [7:0]  row_sel;
   logic [7:0]  col_data;
   logic        frame_done;
   logic        frame_pending;

   led_matrix_scanner #(.ROW_HOLD_CYCLES(H), .BLANK_CYCLES(B)) dut (
      .clk          (clk),
      .rst          (rst),
      .frame_in     (frame_in),
      .frame_valid  (frame_valid),
      .row_sel      (row_sel),
      .col_data     (col_data),
      .frame_done   (frame_done),
      .frame_pending(frame_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Model: mode 0 idle, 1 load cycle, 2 scanning at position m_pos of a frame.
   int          m_mode;
   int          m_pos;
   logic [63:0] m_act, m_pend;
   bit          m_pfull, m_d1;
   logic [7:0]  e_row, e_col;
   logic        e_done, e_pend;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_pos = 0; m_act = '0; m_pend = '0; m_pfull = 0; m_d1 = 0;
      e_row = '0; e_col = '0; e_done = 0; e_pend = 0;
   endtask

   // Outputs seen after an edge reflect the scan position held before it.
   task automatic model_edge(input bit fv, input logic [63:0] fin);
      int r;
      int old_mode;
      bit old_pfull;
      e_row = '0;
      e_col = '0;
      if (m_mode == 2 && (m_pos % P) < H) begin
         r     = m_pos / P;
         e_row = 8'(1 << r);
         e_col = m_act[8*r +: 8];
      end
      e_done    = m_d1;
      m_d1      = 0;
      old_mode  = m_mode;
      old_pfull = m_pfull;
      case (m_mode)
         0: if (fv || m_pfull) m_mode = 1;
         1: begin m_act = m_pend; m_mode = 2; m_pos = 0; end
         default: begin
            if (m_pos == FR - 1) begin
               m_d1 = 1;
               if (old_pfull) m_mode = 1;
               else m_pos = 0;
            end else begin
               m_pos++;
            end
         end
      endcase
      if (fv) begin m_pend = fin; m_pfull = 1; end
      else if (old_mode == 1) m_pfull = 0;
      e_pend = m_pfull;
   endtask

   task automatic tick(input bit fv, input logic [63:0] fin);
      frame_valid = fv;
      frame_in    = fin;
      @(posedge clk);
      if (!rst) model_reset();
      else model_edge(fv, fin);
      #1;
      cyc++;
      check("row_sel", row_sel, e_row);
      check("col_data", col_data, e_col);
      check("frame_done", frame_done, e_done);
      check("frame_pending", frame_pending, e_pend);
      frame_valid = 1'b0;
   endtask

   task automatic wait_row(input logic [7:0] target, input string tag);
      bit found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick(0, '0);
         if (row_sel === target) found = 1;
      end
      check(tag, found, 1);
   endtask

   task automatic wait_done(input string tag);
      bit found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick(0, '0);
         if (frame_done === 1'b1) found = 1;
      end
      check(tag, found, 1);
   endtask

   localparam logic [63:0] F1 = 64'h0808_0818_181C_3C3C;

   initial begin
      logic [63:0] fa, fb, fc, fd;
      int lit_t, done_t;
      rst = 1'b0; frame_valid = 1'b0; frame_in = '0;
      model_reset();

      // Power-up reset, then idle with no frame.
      for (int i = 0; i < 3; i++) tick(0, '0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) tick(0, '0);
      check("idle_row_sel", row_sel, 8'h00);

      // Single frame: row 0 lights two edges after the valid edge.
      tick(1, F1);
      check("pending_after_e0", frame_pending, 1'b1);
      tick(0, '0);
      tick(0, '0);
      check("first_row_sel", row_sel, 8'h01);
      check("first_col", col_data, 8'h3C);
      lit_t  = cyc;
      done_t = -1;
      for (int i = 0; i < 100; i++) begin
         tick(0, '0);
         if (frame_done === 1'b1 && done_t < 0) begin
            done_t = cyc;
            check("rescan_no_gap", row_sel, 8'h01);
         end
      end
      check("done_latency", 64'(done_t - lit_t), 64'd48);

      // Asynchronous reset mid-scan while row 3 is lit.
      wait_row(8'h08, "wait_row3_timeout");
      #1 rst = 1'b0;
      #1;
      check("rst_row_sel", row_sel, 8'h00);
      check("rst_col_data", col_data, 8'h00);
      check("rst_frame_pending", frame_pending, 1'b0);
      model_reset();
      tick(0, '0);
      tick(0, '0);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) tick(0, '0);

      // Tear-free update: new frame during row 3 waits for the frame boundary.
      tick(1, F1);
      wait_row(8'h08, "wait_tear_row3_timeout");
      tick(1, 64'hFFFF_FFFF_FFFF_FFFF);
      check("tear_pending", frame_pending, 1'b1);
      wait_done("wait_tear_done_timeout");
      check("load_gap_row_sel", row_sel, 8'h00);
      tick(0, '0);
      check("new_frame_row0", col_data, 8'hFF);

      // Overwrite: A then B in one scan, only B is shown.
      fb = {$urandom, $urandom};
      fa = ~fb;
      for (int i = 0; i < 5; i++) tick(0, '0);
      tick(1, fa);
      for (int i = 0; i < 7; i++) tick(0, '0);
      tick(1, fb);
      wait_done("wait_ovr_done_timeout");
      tick(0, '0);
      check("overwrite_row0", col_data, fb[7:0]);
      for (int i = 0; i < FR; i++) tick(0, '0);

      // Collision: C arrives in the LOAD cycle of D.
      fd = {$urandom, $urandom};
      fc = ~fd;
      tick(1, fd);
      begin
         bit found = 0;
         for (int i = 0; i < 200 && !found; i++) begin
            if (m_mode == 1) found = 1;
            else tick(0, '0);
         end
         check("wait_load_timeout", found, 1);
      end
      tick(1, fc);
      check("collision_pending", frame_pending, 1'b1);
      tick(0, '0);
      tick(0, '0);
      check("collision_shows_d", col_data, fd[7:0]);
      wait_done("wait_col_done_timeout");
      tick(0, '0);
      check("collision_then_c", col_data, fc[7:0]);
      for (int i = 0; i < 10; i++) tick(0, '0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
